// File: rtl/if_queue_pkg.sv
// if_queue_pkg: shared types and default sizing for the instruction prefetch queue
package if_queue_pkg;
   localparam int IFQ_DEPTH  = 4;
   localparam int IFQ_DATA_W = 32;
   localparam int IFQ_PTR_W  = $clog2(IFQ_DEPTH);
   typedef struct packed {
      logic [IFQ_DATA_W-1:0] pc;
      logic [IFQ_DATA_W-1:0] instr;
   } if_entry_t;
endpackage

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: circular prefetch FIFO between fetch and decode, flushed by taken branches
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   flush             : taken branch, discards all contents (rst has priority)
//   in_valid/in_pc/in_instr, in_ready, fetch_freeze : fetch side, freeze = ~in_ready
//   out_valid/out_pc/out_instr, out_ready           : decode side, outputs 0 when empty
//   count             : current occupancy
module if_fetch_queue
   import if_queue_pkg::*;
#(
   parameter int DEPTH  = IFQ_DEPTH,
   parameter int DATA_W = IFQ_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_pc,
   input  logic [DATA_W-1:0]          in_instr,
   output logic                       in_ready,
   output logic                       fetch_freeze,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_pc,
   output logic [DATA_W-1:0]          out_instr,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   if_entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic push, pop;
   // ready depends only on count so fetch freeze has no path from out_ready
   assign in_ready     = count != (PW+1)'(DEPTH);
   assign fetch_freeze = ~in_ready;
   assign out_valid    = count != '0;
   assign push         = in_valid & in_ready & ~flush;
   assign pop          = out_valid & out_ready & ~flush;
   assign out_pc       = out_valid ? mem[rd_ptr].pc : '0;
   assign out_instr    = out_valid ? mem[rd_ptr].instr : '0;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end
   // storage is never cleared; stale entries are hidden by count
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
   end
endmodule
